// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_pkg
//  Purpose  : Shared types and default widths for the two-requester ALU
//             sharing arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

  // Default operand/result and opcode widths (8-bit ALU, 16 operations).
  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 4;

  // Arbiter control states: waiting for a command, ALU evaluating, result held.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // One ALU command as presented by a requester at the default widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [OP_W_DEF-1:0]   op;
  } req_t;

endpackage : alu_share_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-way round-robin grant. A lone requester wins
//             outright; on a tie the requester that was not granted last wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Pick the winner; the id is only meaningful while gnt_valid_o is high.
  always_comb begin
    gnt_valid_o = |valid_i;
    gnt_id_o    = 1'b0;
    if (valid_i == 2'b11) begin
      gnt_id_o = ~last_grant_i;
    end else begin
      gnt_id_o = valid_i[1];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Shares one combinational ALU between two requesters. Accepts one
//             command at a time (round-robin), registers the ALU operands,
//             captures the result one cycle later and returns it tagged with
//             the requester id over a valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,

  output logic              busy
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q;
  logic                last_grant_q;   // id of the last requester whose response completed
  logic                id_q;           // id of the command currently in flight
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [OP_W-1:0]     alu_op_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_y_q;

  // --------------------------------------------------------------------------
  // Arbitration and command selection
  // --------------------------------------------------------------------------
  logic                gnt_valid;
  logic                gnt_id;
  logic                accept;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [OP_W-1:0]     sel_op;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  // Ready is offered only in IDLE and only to the winner, so it can never be
  // raised toward a requester whose valid is low.
  assign accept     = (state_q == IDLE) && gnt_valid;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;

  assign sel_a  = gnt_id ? req1_a  : req0_a;
  assign sel_b  = gnt_id ? req1_b  : req0_b;
  assign sel_op = gnt_id ? req1_op : req0_op;

  // --------------------------------------------------------------------------
  // Control FSM with registered ALU operands and response outputs
  // --------------------------------------------------------------------------
  // Accept in IDLE, let the ALU settle for one ISSUE cycle, hold the result in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Operands change only here, so the ALU inputs are stable otherwise.
          if (accept) begin
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            alu_op_q <= sel_op;
            id_q     <= gnt_id;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // Registered operands have been stable for a full cycle; capture.
          rsp_y_q     <= alu_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Fairness history advances only when the result is consumed.
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            last_grant_q <= rsp_id_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = (state_q != IDLE);

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Self-checking bench for alu_share_arbiter with a behavioural
//             ALU and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_y, rsp_y;
  logic [3:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_id, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural 16-operation ALU; also the reference for expected results.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return {a[6:0], 1'b0};
      4'd7:  return {1'b0, a[7:1]};
      4'd8:  return a + 8'd1;
      4'd9:  return a - 8'd1;
      4'd10: return a;
      4'd11: return b;
      4'd12: return {a[6:0], a[7]};
      4'd13: return {a[0], a[7:1]};
      4'd14: return (a < b) ? 8'd1 : 8'd0;
      default: return p[7:0];
    endcase
  endfunction

  assign alu_y = alu_ref(alu_a, alu_b, alu_op);

  alu_share_arbiter #(.DATA_W(8), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (alu_a !== 8'h00) $display("FAIL reset_alu_a: got %h want 00", alu_a); else n_pass++;
    n_checks++; if (alu_b !== 8'h00) $display("FAIL reset_alu_b: got %h want 00", alu_b); else n_pass++;
    n_checks++; if (alu_op !== 4'h0) $display("FAIL reset_alu_op: got %h want 0", alu_op); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b want 0", rsp_id); else n_pass++;
    n_checks++; if (rsp_y !== 8'h00) $display("FAIL reset_rsp_y: got %h want 00", rsp_y); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    req0_a = 8'h12; req0_b = 8'h34; req0_op = 4'h0; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready0: got %b want 1", req0_ready); else n_pass++;
    n_checks++; if (req1_ready !== 1'b0) $display("FAIL single_ready1: got %b want 0", req1_ready); else n_pass++;
    tick();
    req0_valid = 1'b0;
    #1;
    n_checks++; if (req0_ready !== 1'b0) $display("FAIL single_ready_pulse: got %b want 0", req0_ready); else n_pass++;
    n_checks++; if (alu_a !== 8'h12) $display("FAIL single_alu_a: got %h want 12", alu_a); else n_pass++;
    n_checks++; if (alu_b !== 8'h34) $display("FAIL single_alu_b: got %h want 34", alu_b); else n_pass++;
    n_checks++; if (alu_op !== 4'h0) $display("FAIL single_alu_op: got %h want 0", alu_op); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", rsp_valid); else n_pass++;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_y !== 8'h46) $display("FAIL single_rsp_y: got %h want 46", rsp_y); else n_pass++;
    n_checks++; if (rsp_id !== 1'b0) $display("FAIL single_rsp_id: got %b want 0", rsp_id); else n_pass++;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_tie;
    do_reset();
    req0_a = 8'h01; req0_b = 8'h01; req0_op = 4'h0; req0_valid = 1'b1;
    req1_a = 8'hFF; req1_b = 8'h01; req1_op = 4'h0; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL tie_first_grant: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_y !== 8'h02 || rsp_id !== 1'b0)
      $display("FAIL tie_rsp0: got v=%b y=%h id=%b want v=1 y=02 id=0", rsp_valid, rsp_y, rsp_id); else n_pass++;
    tick();
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL tie_second_grant: got %b want 10", {req1_ready, req0_ready}); else n_pass++;
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_y !== 8'h00 || rsp_id !== 1'b1)
      $display("FAIL tie_rsp1: got v=%b y=%h id=%b want v=1 y=00 id=1", rsp_valid, rsp_y, rsp_id); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_fairness;
    int acc_n = 0;
    int rsp_n = 0;
    int last_acc = -1;
    do_reset();
    req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h2; req0_valid = 1'b1;
    req1_a = 8'h30; req1_b = 8'h40; req1_op = 4'h3; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && rsp_n < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        if (acc_n < 4) begin
          n_checks++; if (req1_ready !== acc_n[0]) $display("FAIL fair_grant_%0d: got id %b want %b", acc_n, req1_ready, acc_n[0]); else n_pass++;
          if (acc_n > 0) begin
            n_checks++; if (c - last_acc != 3) $display("FAIL fair_spacing_%0d: got %0d want 3", acc_n, c - last_acc); else n_pass++;
          end
        end
        last_acc = c;
        acc_n++;
      end
      if (rsp_valid) begin
        n_checks++; if (rsp_id !== rsp_n[0]) $display("FAIL fair_rsp_id_%0d: got %b want %b", rsp_n, rsp_id, rsp_n[0]); else n_pass++;
        rsp_n++;
      end
      tick();
    end
    n_checks++; if (rsp_n != 4) $display("FAIL fair_rsp_count: got %0d want 4", rsp_n); else n_pass++;
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_backpressure;
    int k = 0;
    logic [7:0] cap_y;
    logic       cap_id;
    do_reset();
    req0_a = 8'h5A; req0_b = 8'h0F; req0_op = 4'h1; req0_valid = 1'b1;
    req1_a = 8'h11; req1_b = 8'h22; req1_op = 4'h0; req1_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    #1;
    while (!rsp_valid && k < 6) begin tick(); #1; k++; end
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_timeout: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_y !== 8'h4B || rsp_id !== 1'b0) $display("FAIL bp_rsp_value: got y=%h id=%b want y=4b id=0", rsp_y, rsp_id); else n_pass++;
    cap_y  = rsp_y;
    cap_id = rsp_id;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_y !== cap_y || rsp_id !== cap_id)
        $display("FAIL bp_hold_%0d: got v=%b y=%h id=%b want v=1 y=%h id=%b", i, rsp_valid, rsp_y, rsp_id, cap_y, cap_id); else n_pass++;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL bp_ready_%0d: got %b want 00", i, {req1_ready, req0_ready}); else n_pass++;
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL bp_release: got busy=%b v=%b want 0 0", busy, rsp_valid); else n_pass++;
    n_checks++; if (req1_ready !== 1'b1) $display("FAIL bp_next_grant: got %b want 1", req1_ready); else n_pass++;
    idle_inputs();
    tick();
    do_reset();
  endtask

  task automatic test_reset_mid;
    do_reset();
    rsp_ready = 1'b1;
    req0_a = 8'h07; req0_b = 8'h03; req0_op = 4'h0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    // requester 0 has now been served, so a surviving fairness history would favour requester 1
    req0_a = 8'h44; req0_b = 8'h55; req0_op = 4'h4; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 4'h0)
      $display("FAIL rmid_alu: got a=%h b=%h op=%h want 00 00 0", alu_a, alu_b, alu_op); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp_%0d: got %b want 0", i, rsp_valid); else n_pass++;
      tick();
      #1;
    end
    req0_valid = 1'b1;
    req1_a = 8'h01; req1_b = 8'h02; req1_op = 4'h0; req1_valid = 1'b1;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL rmid_tie: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_opcode_sweep;
    int k;
    logic [7:0] exp_y;
    do_reset();
    rsp_ready = 1'b1;
    for (int o = 0; o < 16; o++) begin
      req1_a = 8'hA5; req1_b = 8'h3C; req1_op = 4'(o); req1_valid = 1'b1;
      exp_y = alu_ref(8'hA5, 8'h3C, 4'(o));
      #1;
      k = 0;
      while (!req1_ready && k < 8) begin tick(); #1; k++; end
      n_checks++; if (req1_ready !== 1'b1) $display("FAIL sweep_ready_op%0d: got %b want 1", o, req1_ready); else n_pass++;
      tick();
      req1_valid = 1'b0;
      #1;
      k = 0;
      while (!rsp_valid && k < 8) begin tick(); #1; k++; end
      n_checks++; if (rsp_valid !== 1'b1 || rsp_y !== exp_y || rsp_id !== 1'b1)
        $display("FAIL sweep_op%0d: got v=%b y=%h id=%b want v=1 y=%h id=1", o, rsp_valid, rsp_y, rsp_id, exp_y); else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Transaction-level model: the shared unit is either free or holds one
  // command whose result becomes visible two cycles after acceptance and
  // stays until consumed; ties go to whoever was not served last.
  task automatic test_random;
    bit         m_busy = 1'b0;
    bit         m_id   = 1'b0;
    bit         m_last = 1'b1;
    int         m_acc  = 0;
    logic [7:0] m_y    = 8'h00;
    bit         hold0  = 1'b0;
    bit         hold1  = 1'b0;
    bit         er0, er1, erv;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom);
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      er0 = !m_busy && req0_valid && (!req1_valid || m_last);
      er1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      erv = m_busy && (c - m_acc >= 2);
      n_checks++; if (req0_ready !== er0) $display("FAIL rnd_ready0 c%0d: got %b want %b", c, req0_ready, er0); else n_pass++;
      n_checks++; if (req1_ready !== er1) $display("FAIL rnd_ready1 c%0d: got %b want %b", c, req1_ready, er1); else n_pass++;
      n_checks++; if (rsp_valid !== erv) $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, erv); else n_pass++;
      n_checks++; if (busy !== m_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy); else n_pass++;
      if (erv) begin
        n_checks++; if (rsp_y !== m_y || rsp_id !== m_id)
          $display("FAIL rnd_rsp c%0d: got y=%h id=%b want y=%h id=%b", c, rsp_y, rsp_id, m_y, m_id); else n_pass++;
      end
      if (erv && rsp_ready) begin
        m_busy = 1'b0;
        m_last = m_id;
      end else if (er0 || er1) begin
        m_busy = 1'b1;
        m_acc  = c;
        m_id   = er1;
        m_y    = er1 ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op);
      end
      hold0 = req0_valid && !er0;
      hold1 = req1_valid && !er1;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_opcode_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_share_arbiter
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 8-bit ALU between two requesters (e.g. host test sequencer and a local control FSM).
- Round-robin arbitration; accepts one command at a time and drives the registered ALU operand/opcode inputs.
- Captures the combinational ALU result and returns it tagged with the requester id over a valid/ready response channel.
- Sits directly in front of the ALU instance; the ALU stays purely combinational.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 4, opcode width (16 ALU operations).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- req0_op  in  OP_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0.
- alu_a  out  DATA_W  registered operand A to ALU.
- alu_b  out  DATA_W  registered operand B to ALU.
- alu_op  out  OP_W  registered opcode to ALU.
- alu_y  in  DATA_W  combinational ALU result.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_y  out  DATA_W  captured result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE; alu_a=0, alu_b=0, alu_op=0; rsp_valid=0, rsp_id=0, rsp_y=0; last_grant=1, so requester 0 wins the first tie; busy=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant: if exactly one reqN_valid is high, grant N. If both are high, grant the requester that is not last_grant.
  - Ready: reqN_ready is combinational, and is high only in IDLE and only for the granted N.
  - Ready never asserts while reqN_valid is low.
  - On handshake (valid & ready): latch that requester's a/b/op into alu_a/alu_b/alu_op, latch the id, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (1 cycle): the ALU sees the stable registered inputs. At the end of the cycle, rsp_y <= alu_y, rsp_id <= id, rsp_valid <= 1, go to RESP.
- RESP:
  - Hold rsp_valid/rsp_y/rsp_id stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, last_grant <= rsp_id, go to IDLE.
  - Both req_ready stay low throughout RESP.
- Operand hold: alu_a/alu_b/alu_op hold their last values outside of an accept; they only change on an accept.
- Latency: accept at cycle T, rsp_valid high at T+2. Minimum spacing between accepts is 3 cycles (with rsp_ready tied high).
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1.
- Requests in non-IDLE states: a request asserted while busy waits; a requester must hold valid and its payload until ready.
- Reset mid-operation: the in-flight command is discarded, no response is produced, and all outputs return to their reset values on the next edge.
- Result width: rsp_y is exactly DATA_W bits; no carry or flag handling here.

Decomposition:
- Package alu_share_pkg:
  - state enum (IDLE, ISSUE, RESP);
  - DATA_W/OP_W default localparams;
  - req_t struct {a, b, op}.
- Sub-module rr_arb2: combinational 2-way round-robin grant from valid[1:0] and last_grant. It is the natural split, reusable for other shared units.
- Everything else stays inline.

Test Plan:
- Single request: req0 a=8'h12, b=8'h34, op=4'h0 (ADD in the bench ALU).
  - req0_ready pulses for one cycle.
  - alu_a=8'h12, alu_b=8'h34 in ISSUE.
  - rsp_valid at T+2 with rsp_y=8'h46, rsp_id=0.
- Simultaneous requests after reset: req0 (8'h01, 8'h01, op 0) and req1 (8'hFF, 8'h01, op 0).
  - req0 is served first: rsp_y=8'h02, id=0.
  - Then req1: rsp_y=8'h00 (wrap), id=1.
- Continuous dual valid for 4 transactions, rsp_ready=1 -> rsp_id sequence 0,1,0,1; accepts exactly 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid/rsp_y/rsp_id stay stable.
  - req0_ready and req1_ready stay 0.
  - Release -> IDLE the next cycle.
- Reset in ISSUE: assert rst for one cycle.
  - No rsp_valid appears.
  - alu_a/alu_b/alu_op=0, busy=0.
  - A subsequent tie grants req0.
- Opcode sweep: req1 cycles op 0..15 with a=8'hA5, b=8'h3C -> each rsp_y matches the ALU reference model, rsp_id=1 every time.
